// File: rtl/seq_code_lock.sv
// Sequential code lock: multi-digit entry on select presses, with grant/deny
// reporting, consecutive-failure counting and a timed lockout.
module seq_code_lock #(
    parameter int                          DATA_W         = 4,
    parameter int                          SEQ_LEN        = 4,
    parameter logic [DATA_W*SEQ_LEN-1:0]   CODE           = 16'h5B18,
    parameter int                          MAX_FAILS      = 3,
    parameter int                          LOCKOUT_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [DATA_W-1:0]              data,
    input  logic                           select,
    output logic [2:0]                     out,
    output logic [$clog2(SEQ_LEN+1)-1:0]   digit_cnt,
    output logic [3:0]                     fail_cnt
);

    localparam int CNT_W  = $clog2(SEQ_LEN + 1);
    localparam int CODE_W = DATA_W * SEQ_LEN;
    localparam int LK_W   = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [2:0] OUT_IDLE  = 3'b000;
    localparam logic [2:0] OUT_ENTER = 3'b001;
    localparam logic [2:0] OUT_GRANT = 3'b010;
    localparam logic [2:0] OUT_DENY  = 3'b100;
    localparam logic [2:0] OUT_LOCK  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_GRANT,
        S_DENY,
        S_LOCK
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q;
    logic               mism_q, mism_d;
    logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
    logic [3:0]         fail_cnt_q, fail_cnt_d;
    logic [LK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [2:0]         out_q, out_d;

    logic               press;
    logic [CNT_W-1:0]   idx;
    logic [CODE_W-1:0]  code_sh;
    logic [DATA_W-1:0]  exp_digit;
    logic               miss;
    logic               mism_all;
    logic [CNT_W-1:0]   cnt_next;
    logic [4:0]         fail_inc;

    // Both stages idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= select;
            s2_q <= s1_q;
        end
    end

    assign press = s2_q & ~s1_q;

    // A press outside ENTER always starts a fresh entry at digit 0.
    assign idx       = (state_q == S_ENTER) ? digit_cnt_q : '0;
    assign code_sh   = CODE >> (DATA_W * (SEQ_LEN - 1 - int'(idx)));
    assign exp_digit = code_sh[DATA_W-1:0];
    assign miss      = (data != exp_digit);
    assign mism_all  = mism_q | miss;
    assign cnt_next  = digit_cnt_q + CNT_W'(1);
    assign fail_inc  = {1'b0, fail_cnt_q} + 5'd1;

    always_comb begin
        state_d     = state_q;
        mism_d      = mism_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        unique case (state_q)
            S_IDLE, S_GRANT, S_DENY: begin
                if (press) begin
                    mism_d      = miss;
                    digit_cnt_d = CNT_W'(1);
                    state_d     = S_ENTER;
                end
            end
            S_ENTER: begin
                if (press) begin
                    mism_d      = mism_all;
                    digit_cnt_d = cnt_next;
                    if (cnt_next == CNT_W'(SEQ_LEN)) begin
                        if (!mism_all) begin
                            state_d    = S_GRANT;
                            fail_cnt_d = 4'd0;
                        end else if (fail_inc < 5'(MAX_FAILS)) begin
                            state_d    = S_DENY;
                            fail_cnt_d = fail_inc[3:0];
                        end else begin
                            state_d    = S_LOCK;
                            fail_cnt_d = 4'(MAX_FAILS);
                            lock_cnt_d = LK_W'(LOCKOUT_CYCLES - 1);
                        end
                    end
                end
            end
            S_LOCK: begin
                if (lock_cnt_q == '0) begin
                    state_d     = S_IDLE;
                    fail_cnt_d  = 4'd0;
                    digit_cnt_d = '0;
                    mism_d      = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LK_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_d = OUT_IDLE;
        unique case (state_d)
            S_IDLE:  out_d = OUT_IDLE;
            S_ENTER: out_d = OUT_ENTER;
            S_GRANT: out_d = OUT_GRANT;
            S_DENY:  out_d = OUT_DENY;
            S_LOCK:  out_d = OUT_LOCK;
            default: out_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mism_q      <= 1'b0;
            digit_cnt_q <= '0;
            fail_cnt_q  <= 4'd0;
            lock_cnt_q  <= '0;
            out_q       <= OUT_IDLE;
        end else begin
            state_q     <= state_d;
            mism_q      <= mism_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            out_q       <= out_d;
        end
    end

    assign out       = out_q;
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_seq_code_lock.sv
// Directed bench for seq_code_lock: entry, deny, lockout timing, edge
// discipline and asynchronous reset, checked with immediate assertions.
module tb_seq_code_lock;

    localparam int LOCK_CYC = 16;

    logic       clk;
    logic       reset_n;
    logic [3:0] data;
    logic       select;
    logic [2:0] out;
    logic [2:0] digit_cnt;
    logic [3:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    seq_code_lock #(
        .DATA_W         (4),
        .SEQ_LEN        (4),
        .CODE           (16'h5B18),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (LOCK_CYC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data      (data),
        .select    (select),
        .out       (out),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [2:0] o,
                            input logic [2:0] dc, input logic [3:0] fc);
        check({tag, ".out"}, {5'd0, out}, {5'd0, o});
        check({tag, ".dcnt"}, {5'd0, digit_cnt}, {5'd0, dc});
        check({tag, ".fcnt"}, {4'd0, fail_cnt}, {4'd0, fc});
    endtask

    task automatic press_digit(input logic [3:0] d);
        @(negedge clk);
        data   = d;
        select = 1'b0;
        repeat (3) @(negedge clk);
        select = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic enter_code(input logic [15:0] c);
        press_digit(c[15:12]);
        press_digit(c[11:8]);
        press_digit(c[7:4]);
        press_digit(c[3:0]);
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_st("async_rst", 3'b000, 3'd0, 4'd0);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        select  = 1'b1;
        data    = 4'h0;
        repeat (3) @(negedge clk);
        check_st("reset", 3'b000, 3'd0, 4'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_st("post_reset", 3'b000, 3'd0, 4'd0);

        // First press with latency check: two edges after the fall.
        data   = 4'h5;
        select = 1'b0;
        @(negedge clk);
        check("lat_edge1", {5'd0, out}, 8'h00);
        @(negedge clk);
        check_st("lat_edge2", 3'b001, 3'd1, 4'd0);
        select = 1'b1;
        repeat (3) @(negedge clk);
        press_digit(4'hB);
        check_st("good_d2", 3'b001, 3'd2, 4'd0);
        press_digit(4'h1);
        check_st("good_d3", 3'b001, 3'd3, 4'd0);
        press_digit(4'h8);
        check_st("good_grant", 3'b010, 3'd4, 4'd0);

        // Wrong code, then the next press starts a new entry.
        enter_code(16'h5B19);
        check_st("wrong1", 3'b100, 3'd4, 4'd1);
        press_digit(4'h5);
        check_st("restart", 3'b001, 3'd1, 4'd1);
        press_digit(4'hB);
        press_digit(4'h1);
        press_digit(4'h9);
        check_st("wrong2", 3'b100, 3'd4, 4'd2);

        // Third consecutive deny enters lockout on the final edge.
        press_digit(4'h0);
        press_digit(4'h0);
        press_digit(4'h0);
        @(negedge clk);
        data   = 4'h0;
        select = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_st("lock_enter", 3'b110, 3'd4, 4'd3);
        for (int i = 1; i < LOCK_CYC; i++) begin
            select = (i < 12 && (i % 2) == 0) ? 1'b0 : 1'b1;
            data   = 4'(i);
            @(posedge clk);
            @(negedge clk);
        end
        check_st("lock_last", 3'b110, 3'd4, 4'd3);
        @(posedge clk);
        @(negedge clk);
        check_st("lock_exit", 3'b000, 3'd0, 4'd0);

        // A grant clears the failure count.
        enter_code(16'h1234);
        check_st("fc_w1", 3'b100, 3'd4, 4'd1);
        enter_code(16'h5B1A);
        check_st("fc_w2", 3'b100, 3'd4, 4'd2);
        enter_code(16'h5B18);
        check_st("fc_grant", 3'b010, 3'd4, 4'd0);
        enter_code(16'hAB18);
        check_st("fc_w3", 3'b100, 3'd4, 4'd1);

        // Held-low select counts once; release and data wiggle count nothing.
        async_reset_pulse();
        check_st("idle_again", 3'b000, 3'd0, 4'd0);
        data   = 4'h3;
        select = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i > 2) data = 4'(i);
        end
        check_st("hold_low", 3'b001, 3'd1, 4'd0);
        select = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            data = 4'(i + 7);
        end
        check_st("release", 3'b001, 3'd1, 4'd0);

        // Reset mid-entry aborts, then a correct entry grants.
        press_digit(4'hB);
        check_st("mid_entry", 3'b001, 3'd2, 4'd0);
        async_reset_pulse();
        check_st("after_abort", 3'b000, 3'd0, 4'd0);
        enter_code(16'h5B18);
        check_st("abort_grant", 3'b010, 3'd4, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
